// File: rtl/bp_me_mem_cmd_arbiter.sv
// Shares one memory command/response channel pair among num_req_p requesters; responses follow grant order.
// Define BP_ME_MEM_CMD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
`timescale 1ns/1ps
module bp_me_mem_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int cmd_width_p       = 128,
    parameter int resp_width_p      = 128,
    parameter int max_outstanding_p = 4,
    localparam int cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_yumi_o,
    output logic [cmd_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_yumi_i,
    input  logic [resp_width_p-1:0]          mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_ready_o,
    output logic [resp_width_p-1:0]          req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_ready_i,
    output logic [cnt_width_lp-1:0]          outstanding_o,
    output logic                             err_o
);

    localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_outstanding_p);
    localparam logic [id_width_lp-1:0]  last_id_lp = id_width_lp'(num_req_p - 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                  state_reg, state_next;
    logic [cmd_width_p-1:0]  cmd_reg;
    logic [cnt_width_lp-1:0] count_reg;
    logic [ptr_width_lp-1:0] head_reg, tail_reg;
    logic                    err_reg;
    logic [id_width_lp-1:0]  fifo_mem [max_outstanding_p];

    logic [id_width_lp-1:0]  winner;
    logic                    found;
    logic                    grant;
    logic                    pop;
    logic                    empty;
    logic [id_width_lp-1:0]  head_id;
    logic [num_req_p-1:0]    head_sel;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

`ifdef BP_ME_MEM_CMD_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!found && req_cmd_v_i[i]) begin
                winner = id_width_lp'(i);
                found  = 1'b1;
            end
        end
    end
`else
    logic [id_width_lp-1:0] rr_reg;
    int                     idx;

    // Search starts at the rr pointer and wraps, so the last winner has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = (int'(rr_reg) + k) % num_req_p;
            if (!found && req_cmd_v_i[idx]) begin
                winner = id_width_lp'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            rr_reg <= '0;
        else if (grant)
            rr_reg <= (winner == last_id_lp) ? '0 : winner + id_width_lp'(1);
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = SEND;
            SEND:    if (mem_cmd_yumi_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Credit check uses registered occupancy; grant is masked during reset so yumi clears at once.
    always_comb begin
        grant          = reset_n_i && (state_reg == IDLE) && (|req_cmd_v_i) && (count_reg < max_cnt_lp);
        req_cmd_yumi_o = '0;
        if (grant)
            req_cmd_yumi_o[winner] = 1'b1;
        mem_cmd_v_o    = (state_reg == SEND);
    end

    assign mem_cmd_o = cmd_reg;

    always_ff @(posedge clk_i) begin
        if (grant)
            fifo_mem[tail_reg] <= winner;
    end

    assign empty   = (count_reg == '0);
    assign head_id = fifo_mem[head_reg];

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_steer
        assign head_sel[gi]     = (head_id == id_width_lp'(gi));
        assign req_resp_v_o[gi] = mem_resp_v_i && !empty && head_sel[gi];
    end

    assign mem_resp_ready_o = !empty && (|(head_sel & req_resp_ready_i));
    assign req_resp_o       = mem_resp_i;
    assign pop              = mem_resp_v_i && mem_resp_ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_reg   <= '0;
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (grant)
                cmd_reg <= req_cmd_i[int'(winner)*cmd_width_p +: cmd_width_p];
            if (grant)
                tail_reg <= ptr_inc(tail_reg);
            if (pop)
                head_reg <= ptr_inc(head_reg);
            case ({grant, pop})
                2'b10:   count_reg <= count_reg + cnt_width_lp'(1);
                2'b01:   count_reg <= count_reg - cnt_width_lp'(1);
                default: count_reg <= count_reg;
            endcase
            if (mem_resp_v_i && empty)
                err_reg <= 1'b1;
        end
    end

    assign outstanding_o = count_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed bench for bp_me_mem_cmd_arbiter: one task per scenario, inline comparisons against hand-derived values.
`timescale 1ns/1ps
module tb_bp_me_mem_cmd_arbiter;

    localparam int N  = 2;
    localparam int CW = 128;
    localparam int RW = 128;
    localparam int MO = 4;

    logic            clk_i;
    logic            reset_n_i;
    logic [N*CW-1:0] req_cmd_i;
    logic [N-1:0]    req_cmd_v_i;
    logic [N-1:0]    req_cmd_yumi_o;
    logic [CW-1:0]   mem_cmd_o;
    logic            mem_cmd_v_o;
    logic            mem_cmd_yumi_i;
    logic [RW-1:0]   mem_resp_i;
    logic            mem_resp_v_i;
    logic            mem_resp_ready_o;
    logic [RW-1:0]   req_resp_o;
    logic [N-1:0]    req_resp_v_o;
    logic [N-1:0]    req_resp_ready_i;
    logic [2:0]      outstanding_o;
    logic            err_o;

    int n_checks = 0;
    int n_pass   = 0;

    bp_me_mem_cmd_arbiter #(
        .num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW), .max_outstanding_p(MO)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
        .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet_inputs();
        req_cmd_v_i      = '0;
        mem_cmd_yumi_i   = 1'b0;
        mem_resp_v_i     = 1'b0;
        mem_resp_i       = '0;
        req_resp_ready_i = 2'b11;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        req_cmd_i = '0;
        quiet_inputs();
        req_cmd_v_i = 2'b11;
        tick();
        tick();
        #1;
        n_checks++;
        if (req_cmd_yumi_o !== 2'b00) $display("FAIL reset_yumi: got %b want 00", req_cmd_yumi_o); else n_pass++;
        n_checks++;
        if (mem_cmd_v_o !== 1'b0 || mem_cmd_o !== '0) $display("FAIL reset_cmd: got v=%b cmd=%h want v=0 cmd=0", mem_cmd_v_o, mem_cmd_o); else n_pass++;
        n_checks++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0) $display("FAIL reset_state: got outst=%0d err=%b want 0 0", outstanding_o, err_o); else n_pass++;
        n_checks++;
        if (mem_resp_ready_o !== 1'b0 || req_resp_v_o !== 2'b00) $display("FAIL reset_resp: got rdy=%b v=%b want 0 00", mem_resp_ready_o, req_resp_v_o); else n_pass++;
        req_cmd_v_i = '0;
        reset_n_i   = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_cmd_i[1*CW +: CW] = 128'hA5;
        req_cmd_v_i = 2'b10;
        #1;
        n_checks++;
        if (req_cmd_yumi_o !== 2'b10) $display("FAIL single_yumi: got %b want 10", req_cmd_yumi_o); else n_pass++;
        tick();
        req_cmd_v_i = '0;
        #1;
        n_checks++;
        if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 128'hA5) $display("FAIL single_cmd: got v=%b cmd=%h want v=1 cmd=a5", mem_cmd_v_o, mem_cmd_o); else n_pass++;
        n_checks++;
        if (outstanding_o !== 3'd1) $display("FAIL single_outst: got %0d want 1", outstanding_o); else n_pass++;
        mem_cmd_yumi_i = 1'b1;
        tick();
        mem_cmd_yumi_i = 1'b0;
        mem_resp_i     = 128'h3C;
        mem_resp_v_i   = 1'b1;
        #1;
        n_checks++;
        if (req_resp_v_o !== 2'b10 || req_resp_o !== 128'h3C || mem_resp_ready_o !== 1'b1)
            $display("FAIL single_resp: got v=%b data=%h rdy=%b want 10 3c 1", req_resp_v_o, req_resp_o, mem_resp_ready_o);
        else n_pass++;
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        n_checks++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0) $display("FAIL single_drain: got outst=%0d err=%b want 0 0", outstanding_o, err_o); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [1:0] exp_grant;
        req_cmd_i[0*CW +: CW] = 128'h100;
        req_cmd_i[1*CW +: CW] = 128'h101;
        for (int n = 0; n < 8; n++) begin
`ifdef BP_ME_MEM_CMD_ARB_FIXED_PRIO_EN
            exp_grant = 2'b01;
`else
            exp_grant = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
            req_cmd_v_i    = 2'b11;
            mem_cmd_yumi_i = 1'b0;
            mem_resp_v_i   = 1'b0;
            #1;
            n_checks++;
            if (req_cmd_yumi_o !== exp_grant) $display("FAIL fair_grant%0d: got %b want %b", n, req_cmd_yumi_o, exp_grant); else n_pass++;
            tick();
            mem_cmd_yumi_i = 1'b1;
            mem_resp_v_i   = 1'b1;
            #1;
            n_checks++;
            if (req_resp_v_o !== exp_grant || req_cmd_yumi_o !== 2'b00)
                $display("FAIL fair_send%0d: got resp_v=%b yumi=%b want %b 00", n, req_resp_v_o, req_cmd_yumi_o, exp_grant);
            else n_pass++;
            tick();
        end
        quiet_inputs();
        #1;
        n_checks++;
        if (outstanding_o !== 3'd0) $display("FAIL fair_outst: got %0d want 0", outstanding_o); else n_pass++;
    endtask

    task automatic test_credit_limit();
        req_cmd_v_i = 2'b01;
        for (int n = 0; n < 4; n++) begin
            mem_cmd_yumi_i = 1'b0;
            #1;
            n_checks++;
            if (req_cmd_yumi_o !== 2'b01) $display("FAIL credit_grant%0d: got %b want 01", n, req_cmd_yumi_o); else n_pass++;
            tick();
            mem_cmd_yumi_i = 1'b1;
            tick();
        end
        mem_cmd_yumi_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (outstanding_o !== 3'd4 || req_cmd_yumi_o !== 2'b00)
            $display("FAIL credit_full: got outst=%0d yumi=%b want 4 00", outstanding_o, req_cmd_yumi_o);
        else n_pass++;
        mem_resp_v_i = 1'b1;
        #1;
        n_checks++;
        if (req_cmd_yumi_o !== 2'b00) $display("FAIL credit_popcycle: got %b want 00", req_cmd_yumi_o); else n_pass++;
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        n_checks++;
        if (req_cmd_yumi_o !== 2'b01 || outstanding_o !== 3'd3)
            $display("FAIL credit_regrant: got yumi=%b outst=%0d want 01 3", req_cmd_yumi_o, outstanding_o);
        else n_pass++;
        tick();
        req_cmd_v_i    = '0;
        mem_cmd_yumi_i = 1'b1;
        tick();
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i   = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        mem_resp_v_i = 1'b0;
        #1;
        n_checks++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0) $display("FAIL credit_drain: got outst=%0d err=%b want 0 0", outstanding_o, err_o); else n_pass++;
    endtask

    task automatic test_backpressure();
        req_cmd_i[0*CW +: CW] = 128'hB0;
        req_cmd_i[1*CW +: CW] = 128'hB1;
        req_cmd_v_i = 2'b10;
        #1;
        n_checks++;
        if (req_cmd_yumi_o !== 2'b10) $display("FAIL bp_first: got %b want 10", req_cmd_yumi_o); else n_pass++;
        tick();
        req_cmd_v_i    = 2'b01;
        mem_cmd_yumi_i = 1'b1;
        tick();
        mem_cmd_yumi_i = 1'b0;
        #1;
        n_checks++;
        if (req_cmd_yumi_o !== 2'b01) $display("FAIL bp_second: got %b want 01", req_cmd_yumi_o); else n_pass++;
        tick();
        req_cmd_v_i    = '0;
        mem_cmd_yumi_i = 1'b1;
        tick();
        mem_cmd_yumi_i   = 1'b0;
        mem_resp_v_i     = 1'b1;
        mem_resp_i       = 128'h77;
        req_resp_ready_i = 2'b01;
        for (int n = 0; n < 5; n++) begin
            #1;
            n_checks++;
            if (mem_resp_ready_o !== 1'b0 || req_resp_v_o !== 2'b10)
                $display("FAIL bp_hold%0d: got rdy=%b v=%b want 0 10", n, mem_resp_ready_o, req_resp_v_o);
            else n_pass++;
            tick();
        end
        req_resp_ready_i = 2'b11;
        #1;
        n_checks++;
        if (mem_resp_ready_o !== 1'b1 || req_resp_v_o !== 2'b10) $display("FAIL bp_resp1: got rdy=%b v=%b want 1 10", mem_resp_ready_o, req_resp_v_o); else n_pass++;
        tick();
        n_checks++;
        if (mem_resp_ready_o !== 1'b1 || req_resp_v_o !== 2'b01) $display("FAIL bp_resp0: got rdy=%b v=%b want 1 01", mem_resp_ready_o, req_resp_v_o); else n_pass++;
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        n_checks++;
        if (outstanding_o !== 3'd0) $display("FAIL bp_drain: got %0d want 0", outstanding_o); else n_pass++;
    endtask

    task automatic test_stall();
        req_cmd_i[0*CW +: CW] = 128'h1234;
        req_cmd_v_i = 2'b01;
        tick();
        req_cmd_i[0*CW +: CW] = 128'h5678;
        for (int n = 0; n < 10; n++) begin
            #1;
            n_checks++;
            if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 128'h1234 || req_cmd_yumi_o !== 2'b00)
                $display("FAIL stall%0d: got v=%b cmd=%h yumi=%b want 1 1234 00", n, mem_cmd_v_o, mem_cmd_o, req_cmd_yumi_o);
            else n_pass++;
            tick();
        end
        mem_cmd_yumi_i = 1'b1;
        req_cmd_v_i    = '0;
        tick();
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i   = 1'b1;
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        n_checks++;
        if (outstanding_o !== 3'd0 || mem_cmd_v_o !== 1'b0) $display("FAIL stall_done: got outst=%0d v=%b want 0 0", outstanding_o, mem_cmd_v_o); else n_pass++;
    endtask

    task automatic test_error();
        mem_resp_v_i = 1'b1;
        #1;
        n_checks++;
        if (mem_resp_ready_o !== 1'b0 || req_resp_v_o !== 2'b00) $display("FAIL err_empty: got rdy=%b v=%b want 0 00", mem_resp_ready_o, req_resp_v_o); else n_pass++;
        tick();
        mem_resp_v_i = 1'b0;
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_set: got %b want 1", err_o); else n_pass++;
        tick();
        tick();
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        req_cmd_i[0*CW +: CW] = 128'hCAFE;
        req_cmd_v_i = 2'b01;
        tick();
        #1;
        n_checks++;
        if (mem_cmd_v_o !== 1'b1 || outstanding_o !== 3'd1) $display("FAIL areset_pre: got v=%b outst=%0d want 1 1", mem_cmd_v_o, outstanding_o); else n_pass++;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (mem_cmd_v_o !== 1'b0 || mem_cmd_o !== '0) $display("FAIL areset_cmd: got v=%b cmd=%h want 0 0", mem_cmd_v_o, mem_cmd_o); else n_pass++;
        n_checks++;
        if (err_o !== 1'b0 || outstanding_o !== 3'd0 || req_cmd_yumi_o !== 2'b00)
            $display("FAIL areset_state: got err=%b outst=%0d yumi=%b want 0 0 00", err_o, outstanding_o, req_cmd_yumi_o);
        else n_pass++;
        req_cmd_v_i = '0;
        tick();
        reset_n_i = 1'b1;
        tick();
        n_checks++;
        if (err_o !== 1'b0 || mem_cmd_v_o !== 1'b0) $display("FAIL areset_post: got err=%b v=%b want 0 0", err_o, mem_cmd_v_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_limit();
        test_backpressure();
        test_stall();
        test_error();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got still running want finished");
        $fatal(1);
    end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
Name: bp_me_mem_cmd_arbiter

Overview:
- Shares one CCE-side memory command / response channel pair among num_req_p requesters, e.g. several bp_me_top instances in front of a single bp_me_cce_to_manycore_link bridge.
- Round-robin grants on commands.
- Records each granted requester id in an in-order tracking FIFO.
- Steers in-order memory responses back to the requester at the FIFO head.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- cmd_width_p, 128, packed mem command width (bp_cce_mem_cmd_s).
- resp_width_p, 128, packed mem response width (bp_mem_cce_resp_s).
- max_outstanding_p, 4, tracking FIFO depth; max commands issued but not yet answered.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_cmd_i  in  num_req_p*cmd_width_p  requester commands; slot i at bits [i*cmd_width_p +: cmd_width_p].
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  per-requester command consumed.
- mem_cmd_o  out  cmd_width_p  command to bridge.
- mem_cmd_v_o  out  1  command valid to bridge.
- mem_cmd_yumi_i  in  1  bridge consumed command.
- mem_resp_i  in  resp_width_p  response from bridge.
- mem_resp_v_i  in  1  response valid.
- mem_resp_ready_o  out  1  arbiter can accept the response.
- req_resp_o  out  resp_width_p  response broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- outstanding_o  out  clog2(max_outstanding_p+1)  tracking FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (reset_n_i low, takes effect immediately, asynchronous): all of the following are cleared.
  - State = IDLE; rr pointer = 0.
  - FIFO empty; outstanding_o = 0.
  - err_o = 0; mem_cmd_v_o = 0; mem_cmd_o = 0.
  - req_cmd_yumi_o = 0; req_resp_v_o = 0; mem_resp_ready_o = 0.
  - Any in-flight command register is discarded.
- FSM states: IDLE, SEND.
- IDLE:
  - Grant when any req_cmd_v_i bit is set and outstanding_o < max_outstanding_p. The occupancy used is the registered value; a same-cycle pop does not free a slot.
  - Winner = first valid index at or after the rr pointer, wrapping modulo num_req_p.
  - On grant, in the same cycle: req_cmd_yumi_o[winner] = 1; the command is latched into the output register; the winner id is pushed into the FIFO; state -> SEND.
  - The rr pointer becomes (winner+1) mod num_req_p.
- SEND:
  - mem_cmd_v_o = 1 and mem_cmd_o holds the registered command, stable until mem_cmd_yumi_i.
  - On mem_cmd_yumi_i: state -> IDLE.
  - No new grant is made in the yumi cycle. Minimum spacing is 2 cycles per command. Latency from grant to mem_cmd_v_o is 1 cycle.
- Response path (combinational from the FIFO head h):
  - req_resp_o = mem_resp_i.
  - req_resp_v_o[h] = mem_resp_v_i & ~empty; all other bits 0.
  - mem_resp_ready_o = req_resp_ready_i[h] & ~empty.
  - Pop on mem_resp_v_i & mem_resp_ready_o.
- Simultaneous push and pop: occupancy is unchanged; head advances; tail advances. Pointers wrap modulo max_outstanding_p.
- mem_resp_v_i while the FIFO is empty: mem_resp_ready_o = 0 and err_o is set; it stays set until reset.
- Requester valid deasserted before yumi: not permitted (valid/yumi contract); behaviour unspecified.

Optional Feature:
- Macro: BP_ME_MEM_CMD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins and the rr pointer is removed.
- Undefined: round-robin as described above.

Test Plan:
- Single request: req 1 valid with cmd 0xA5 -> yumi[1] at cycle 0, mem_cmd_v_o at cycle 1 with mem_cmd_o = 0xA5, outstanding_o = 1. Response 0x3C -> req_resp_v_o = 2'b10, outstanding_o = 0.
- Fairness: both requesters continuously valid, bridge yumi immediate -> grant order 0,1,0,1 over 8 commands. With BP_ME_MEM_CMD_ARB_FIXED_PRIO_EN defined -> all grants to 0.
- Credit limit: 4 commands issued with no responses -> outstanding_o = 4 and no yumi while requests stay valid. One response -> the next grant occurs 1 cycle later.
- Response backpressure and steering: issue order 1,0; req_resp_ready_i[1] = 0 for 5 cycles -> mem_resp_ready_o = 0 throughout and req_resp_v_o = 2'b10 held. Then the responses go to 1, then to 0.
- Stall in SEND: mem_cmd_yumi_i held low 10 cycles -> mem_cmd_o stable and no further req_cmd_yumi_o.
- Error and reset: mem_resp_v_i with the FIFO empty -> err_o = 1 and stays set. Asynchronous reset_n_i pulse during SEND -> mem_cmd_v_o = 0, err_o = 0 and outstanding_o = 0 immediately, without waiting for a clock edge.
